// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler
//   Reservation station and issue controller for the single-cycle integer ALU.
//   Holds dispatched ALU ops, captures missing operands from the CDB, selects
//   the oldest ready entry each cycle, drives the combinational ALU, and
//   registers the ALU result into a one-deep writeback slot drained by a
//   valid/ready handshake toward the CDB arbiter.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous squash of all entries and the writeback slot
//   dispatch_*          new op (op, bypass, rob id, dest preg, two sources)
//   dispatch_ready      an entry is free (registered occupancy, no same-cycle reuse)
//   cdb_valid/tag/data  result broadcast used for operand wakeup
//   alu_op/bypass/in_a/in_b  combinational ALU inputs, zero when not issuing
//   alu_out_f           ALU result for the op issued this cycle
//   wb_valid/ready, wb_rob_id/pd/data  writeback slot toward the CDB arbiter
module alu_issue_scheduler #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_valid,
  output logic              dispatch_ready,
  input  logic [3:0]        dispatch_op,
  input  logic              dispatch_bypass,
  input  logic [ROB_W-1:0]  dispatch_rob_id,
  input  logic [PREG_W-1:0] dispatch_pd,
  input  logic              dispatch_src1_rdy,
  input  logic              dispatch_src2_rdy,
  input  logic [PREG_W-1:0] dispatch_src1_tag,
  input  logic [PREG_W-1:0] dispatch_src2_tag,
  input  logic [31:0]       dispatch_src1_val,
  input  logic [31:0]       dispatch_src2_val,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_tag,
  input  logic [31:0]       cdb_data,
  output logic [3:0]        alu_op,
  output logic              alu_bypass,
  output logic [31:0]       alu_in_a,
  output logic [31:0]       alu_in_b,
  input  logic [31:0]       alu_out_f,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ROB_W-1:0]  wb_rob_id,
  output logic [PREG_W-1:0] wb_pd,
  output logic [31:0]       wb_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [3:0]        op;
    logic              bypass;
    logic [ROB_W-1:0]  rob_id;
    logic [PREG_W-1:0] pd;
    logic              s1_rdy;
    logic [PREG_W-1:0] s1_tag;
    logic [31:0]       s1_val;
    logic              s2_rdy;
    logic [PREG_W-1:0] s2_tag;
    logic [31:0]       s2_val;
  } entry_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  // older_q[i][j] set means entry i was dispatched before entry j.
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [DEPTH-1:0]  older_col [DEPTH];

  logic              wb_valid_q, wb_valid_d;
  logic [ROB_W-1:0]  wb_rob_id_q, wb_rob_id_d;
  logic [PREG_W-1:0] wb_pd_q, wb_pd_d;
  logic [31:0]       wb_data_q, wb_data_d;

  logic [DEPTH-1:0]  eligible, sel_oh;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              full, issue, do_disp;
  entry_t            new_ent;

  // ---- select: oldest eligible entry ----
  always_comb begin
    eligible  = '0;
    sel_oh    = '0;
    sel_idx   = '0;
    older_col = '{default: '0};
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = valid_q[i] & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
      for (int j = 0; j < DEPTH; j++) begin
        older_col[i][j] = older_q[j][i];
      end
    end
    // An entry wins when no other eligible entry is older than it; the age
    // relation is a strict total order over valid entries, so at most one wins.
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = eligible[i] & ~(|(eligible & older_col[i]));
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  // ---- dispatch slot and operand capture from a same-cycle broadcast ----
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    new_ent.op     = dispatch_op;
    new_ent.bypass = dispatch_bypass;
    new_ent.rob_id = dispatch_rob_id;
    new_ent.pd     = dispatch_pd;
    new_ent.s1_rdy = dispatch_src1_rdy;
    new_ent.s1_tag = dispatch_src1_tag;
    new_ent.s1_val = dispatch_src1_val;
    new_ent.s2_rdy = dispatch_src2_rdy;
    new_ent.s2_tag = dispatch_src2_tag;
    new_ent.s2_val = dispatch_src2_val;
    if (!dispatch_src1_rdy && cdb_valid && (dispatch_src1_tag == cdb_tag)) begin
      new_ent.s1_rdy = 1'b1;
      new_ent.s1_val = cdb_data;
    end
    if (!dispatch_src2_rdy && cdb_valid && (dispatch_src2_tag == cdb_tag)) begin
      new_ent.s2_rdy = 1'b1;
      new_ent.s2_val = cdb_data;
    end
  end

  assign full           = &valid_q;
  assign dispatch_ready = ~full;
  assign do_disp        = dispatch_valid & ~full & ~flush;
  assign issue          = (|eligible) & (~wb_valid_q | wb_ready) & ~flush;

  // ---- issue: drive the ALU from the selected entry ----
  always_comb begin
    alu_op     = 4'd0;
    alu_bypass = 1'b0;
    alu_in_a   = 32'd0;
    alu_in_b   = 32'd0;
    if (issue) begin
      alu_op     = ent_q[sel_idx].op;
      alu_bypass = ent_q[sel_idx].bypass;
      alu_in_a   = ent_q[sel_idx].s1_val;
      alu_in_b   = ent_q[sel_idx].s2_val;
    end
  end

  // ---- next state: wakeup, free, allocate, writeback ----
  always_comb begin
    valid_d     = valid_q;
    ent_d       = ent_q;
    older_d     = older_q;
    wb_valid_d  = wb_valid_q;
    wb_rob_id_d = wb_rob_id_q;
    wb_pd_d     = wb_pd_q;
    wb_data_d   = wb_data_q;

    // Wakeup only updates the stored ready bits, so a woken entry is first
    // seen as eligible on the following cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!ent_q[i].s1_rdy && (ent_q[i].s1_tag == cdb_tag)) begin
          ent_d[i].s1_rdy = 1'b1;
          ent_d[i].s1_val = cdb_data;
        end
        if (!ent_q[i].s2_rdy && (ent_q[i].s2_tag == cdb_tag)) begin
          ent_d[i].s2_rdy = 1'b1;
          ent_d[i].s2_val = cdb_data;
        end
      end
    end

    if (issue) begin
      valid_d[sel_idx] = 1'b0;
    end

    // free_idx is never the issuing entry: it was invalid this cycle.
    if (do_disp) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = new_ent;
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (IDX_W'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
    end

    if (issue) begin
      wb_valid_d  = 1'b1;
      wb_rob_id_d = ent_q[sel_idx].rob_id;
      wb_pd_d     = ent_q[sel_idx].pd;
      wb_data_d   = alu_out_f;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end

    if (flush) begin
      valid_d    = '0;
      wb_valid_d = 1'b0;
    end
  end

  // ---- state registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_rob_id_q <= '0;
      wb_pd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      wb_valid_q  <= wb_valid_d;
      wb_rob_id_q <= wb_rob_id_d;
      wb_pd_q     <= wb_pd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Entry payload and age bits are only meaningful while valid_q is set.
  always_ff @(posedge clk) begin
    ent_q   <= ent_d;
    older_q <= older_d;
  end

  assign wb_valid  = wb_valid_q;
  assign wb_rob_id = wb_rob_id_q;
  assign wb_pd     = wb_pd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
module tb_alu_issue_scheduler;

  localparam int DEPTH  = 4;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic              clk, rst, flush;
  logic              dispatch_valid, dispatch_ready;
  logic [3:0]        dispatch_op;
  logic              dispatch_bypass;
  logic [ROB_W-1:0]  dispatch_rob_id;
  logic [PREG_W-1:0] dispatch_pd;
  logic              dispatch_src1_rdy, dispatch_src2_rdy;
  logic [PREG_W-1:0] dispatch_src1_tag, dispatch_src2_tag;
  logic [31:0]       dispatch_src1_val, dispatch_src2_val;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_tag;
  logic [31:0]       cdb_data;
  logic [3:0]        alu_op;
  logic              alu_bypass;
  logic [31:0]       alu_in_a, alu_in_b, alu_out_f;
  logic              wb_valid, wb_ready;
  logic [ROB_W-1:0]  wb_rob_id;
  logic [PREG_W-1:0] wb_pd;
  logic [31:0]       wb_data;

  int errors = 0;
  int checks = 0;

  alu_issue_scheduler #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_bypass(dispatch_bypass),
    .dispatch_rob_id(dispatch_rob_id), .dispatch_pd(dispatch_pd),
    .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_src1_val(dispatch_src1_val), .dispatch_src2_val(dispatch_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_op(alu_op), .alu_bypass(alu_bypass), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out_f(alu_out_f),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rob_id(wb_rob_id),
    .wb_pd(wb_pd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External single-cycle ALU
  always_comb begin
    alu_out_f = 32'd0;
    case (alu_op)
      OP_ADD:  alu_out_f = alu_in_a + alu_in_b;
      OP_SUB:  alu_out_f = alu_in_a - alu_in_b;
      OP_SLL:  alu_out_f = alu_in_a << alu_in_b[4:0];
      OP_SLT:  alu_out_f = {31'd0, $signed(alu_in_a) < $signed(alu_in_b)};
      OP_SLTU: alu_out_f = {31'd0, alu_in_a < alu_in_b};
      OP_SRL:  alu_out_f = alu_in_a >> alu_in_b[4:0];
      OP_SRA:  alu_out_f = $unsigned($signed(alu_in_a) >>> alu_in_b[4:0]);
      OP_XOR:  alu_out_f = alu_in_a ^ alu_in_b;
      OP_OR:   alu_out_f = alu_in_a | alu_in_b;
      OP_AND:  alu_out_f = alu_in_a & alu_in_b;
      default: alu_out_f = 32'd0;
    endcase
    if (alu_bypass) alu_out_f = alu_in_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_disp(input logic [3:0] op, input logic byp,
                          input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] pd,
                          input logic r1, input logic [PREG_W-1:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [PREG_W-1:0] t2, input logic [31:0] v2);
    dispatch_valid    = 1'b1;
    dispatch_op       = op;
    dispatch_bypass   = byp;
    dispatch_rob_id   = rob;
    dispatch_pd       = pd;
    dispatch_src1_rdy = r1;
    dispatch_src1_tag = t1;
    dispatch_src1_val = v1;
    dispatch_src2_rdy = r2;
    dispatch_src2_tag = t2;
    dispatch_src2_val = v2;
  endtask

  task automatic clr_disp();
    dispatch_valid = 1'b0;
  endtask

  task automatic set_cdb(input logic [PREG_W-1:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        byp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{OP_ADD,  1'b0, 32'd5,        32'd7,        32'd12};
    vecs[1]  = '{OP_SUB,  1'b0, 32'd3,        32'd5,        32'hFFFF_FFFE};
    vecs[2]  = '{OP_SLL,  1'b0, 32'h3,        32'h21,       32'h6};
    vecs[3]  = '{OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1,       32'd1};
    vecs[4]  = '{OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0};
    vecs[5]  = '{OP_SRL,  1'b0, 32'h8000_0000, 32'd4,       32'h0800_0000};
    vecs[6]  = '{OP_SRA,  1'b0, 32'h8000_0000, 32'd4,       32'hF800_0000};
    vecs[7]  = '{OP_XOR,  1'b0, 32'hF0F0,     32'hFF00,     32'h0FF0};
    vecs[8]  = '{OP_OR,   1'b0, 32'hF0F0,     32'h0F00,     32'hFFF0};
    vecs[9]  = '{OP_AND,  1'b0, 32'hF0F0,     32'hFF00,     32'hF000};
    vecs[10] = '{OP_ADD,  1'b1, 32'd5,        32'h1234_5000, 32'h1234_5000};

    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    set_disp(OP_ADD, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    clr_disp();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);
    chk("reset_alu_in_a", alu_in_a, 32'd0);

    // Basic add: both sources ready
    set_disp(OP_ADD, 1'b0, 5'd3, 6'd9, 1'b1, '0, 32'd5, 1'b1, '0, 32'd7);
    tick();
    clr_disp();
    #1;
    chk("t1_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
    chk("t1_alu_a", alu_in_a, 32'd5);
    chk("t1_alu_b", alu_in_b, 32'd7);
    chk("t1_wb_not_yet", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t1_wb_data", wb_data, 32'd12);
    chk("t1_wb_rob", {27'd0, wb_rob_id}, 32'd3);
    chk("t1_wb_pd", {26'd0, wb_pd}, 32'd9);
    tick();
    chk("t1_wb_drained", {31'd0, wb_valid}, 32'd0);

    // Table of ALU operations
    for (int i = 0; i < 11; i++) begin
      set_disp(vecs[i].op, vecs[i].byp, ROB_W'(i), PREG_W'(i), 1'b1, '0, vecs[i].a,
               1'b1, '0, vecs[i].b);
      tick();
      clr_disp();
      tick();
      chk($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp);
      chk($sformatf("vec%0d_wb_rob", i), {27'd0, wb_rob_id}, i);
    end
    tick();

    // Wakeup: src1 waits on tag 12
    set_disp(OP_SUB, 1'b0, 5'd4, 6'd10, 1'b0, 6'd12, 32'd0, 1'b1, '0, 32'd1);
    tick();
    clr_disp();
    #1;
    chk("t2_no_issue_waiting", alu_in_b, 32'd0);
    tick();
    set_cdb(6'd12, 32'd10);
    #1;
    chk("t2_no_same_cycle_issue", alu_in_b, 32'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t2_issue_op", {28'd0, alu_op}, {28'd0, OP_SUB});
    chk("t2_issue_a", alu_in_a, 32'd10);
    chk("t2_issue_b", alu_in_b, 32'd1);
    tick();
    chk("t2_wb_data", wb_data, 32'd9);

    // Same-edge capture of a broadcast at dispatch
    set_disp(OP_ADD, 1'b0, 5'd5, 6'd11, 1'b0, 6'd7, 32'd0, 1'b1, '0, 32'd2);
    set_cdb(6'd7, 32'd40);
    tick();
    clr_disp();
    cdb_valid = 1'b0;
    #1;
    chk("cap_issue_a", alu_in_a, 32'd40);
    tick();
    chk("cap_wb_data", wb_data, 32'd42);

    // Fill all entries: tags 20,21,22,30 into slots 0..3
    set_disp(OP_ADD, 1'b0, 5'd10, 6'd40, 1'b0, 6'd20, 32'd0, 1'b1, '0, 32'd0);
    tick();
    set_disp(OP_ADD, 1'b0, 5'd11, 6'd41, 1'b0, 6'd21, 32'd0, 1'b1, '0, 32'd1);
    tick();
    set_disp(OP_ADD, 1'b0, 5'd12, 6'd42, 1'b0, 6'd22, 32'd0, 1'b1, '0, 32'd2);
    tick();
    set_disp(OP_ADD, 1'b0, 5'd13, 6'd43, 1'b0, 6'd30, 32'd0, 1'b1, '0, 32'd3);
    tick();
    clr_disp();
    #1;
    chk("t3_full", {31'd0, dispatch_ready}, 32'd0);
    set_cdb(6'd21, 32'd100);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t3_issue_a", alu_in_a, 32'd100);
    chk("t3_issue_b", alu_in_b, 32'd1);
    chk("t3_still_full_on_issue", {31'd0, dispatch_ready}, 32'd0);
    tick();
    chk("t3_ready_after_free", {31'd0, dispatch_ready}, 32'd1);
    chk("t3_wb_data", wb_data, 32'd101);

    // Refill the freed low slot with a younger op on tag 30; the older
    // tag-30 op sits in the highest slot and must issue first.
    set_disp(OP_ADD, 1'b0, 5'd14, 6'd44, 1'b0, 6'd30, 32'd0, 1'b1, '0, 32'd5);
    tick();
    clr_disp();
    set_cdb(6'd30, 32'd1000);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t4_older_first", alu_in_b, 32'd3);
    tick();
    chk("t4_younger_second", alu_in_b, 32'd5);
    chk("t4_first_result", wb_data, 32'd1003);
    chk("t4_first_rob", {27'd0, wb_rob_id}, 32'd13);
    tick();
    chk("t4_back_to_back_valid", {31'd0, wb_valid}, 32'd1);
    chk("t4_second_result", wb_data, 32'd1005);
    chk("t4_second_rob", {27'd0, wb_rob_id}, 32'd14);

    // Writeback stall: hold the slot while a ready entry waits
    wb_ready = 1'b0;
    set_cdb(6'd20, 32'd50);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t5_stall_no_issue", alu_in_a, 32'd0);
    chk("t5_stall_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t5_stall_wb_data", wb_data, 32'd1005);
    tick();
    chk("t5_stall_hold_data", wb_data, 32'd1005);
    chk("t5_stall_hold_pd", {26'd0, wb_pd}, 32'd44);
    wb_ready = 1'b1;
    #1;
    chk("t5_issue_on_ready", alu_in_a, 32'd50);
    tick();
    chk("t5_reload_valid", {31'd0, wb_valid}, 32'd1);
    chk("t5_reload_data", wb_data, 32'd50);
    wb_ready = 1'b0;

    // Flush with three entries valid (tags 22, 40, 41) and wb_valid=1
    set_disp(OP_ADD, 1'b0, 5'd15, 6'd45, 1'b0, 6'd40, 32'd0, 1'b1, '0, 32'd0);
    tick();
    set_disp(OP_ADD, 1'b0, 5'd16, 6'd46, 1'b0, 6'd41, 32'd0, 1'b1, '0, 32'd0);
    tick();
    set_disp(OP_ADD, 1'b0, 5'd17, 6'd47, 1'b1, '0, 32'd77, 1'b1, '0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr_disp();
    #1;
    chk("t6_flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("t6_flush_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);
    chk("t6_flush_discard_dispatch", alu_in_a, 32'd0);
    wb_ready = 1'b1;
    set_cdb(6'd22, 32'd5);
    tick();
    set_cdb(6'd41, 32'd6);
    #1;
    chk("t6_flushed_22_no_issue", alu_in_a, 32'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t6_flushed_41_no_issue", alu_in_a, 32'd0);
    chk("t6_flushed_wb_idle", {31'd0, wb_valid}, 32'd0);

    // Asynchronous reset in mid-cycle
    wb_ready = 1'b0;
    set_disp(OP_ADD, 1'b1, 5'd7, 6'd7, 1'b1, '0, 32'd0, 1'b1, '0, 32'hABCD);
    tick();
    set_disp(OP_ADD, 1'b1, 5'd8, 6'd8, 1'b1, '0, 32'd0, 1'b1, '0, 32'h1111);
    tick();
    clr_disp();
    #1;
    chk("rst_pre_wb_data", wb_data, 32'hABCD);
    wb_ready = 1'b1;
    #1;
    chk("rst_pre_issue_b", alu_in_b, 32'h1111);
    rst = 1'b1;
    #1;
    chk("rst_async_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_async_wb_data", wb_data, 32'd0);
    chk("rst_async_wb_rob", {27'd0, wb_rob_id}, 32'd0);
    chk("rst_async_entries", alu_in_b, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_after_ready", {31'd0, dispatch_ready}, 32'd1);
    chk("rst_after_no_issue", alu_in_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- Reservation station and issue controller for a single-cycle integer ALU in the OoO backend.
- Buffers dispatched ALU ops and captures operands from the common data bus (CDB).
- Picks the oldest ready entry each cycle and drives the ALU's combinational op/bypass/operand inputs.
- Registers the ALU result into a one-deep writeback slot drained by a valid/ready handshake to the CDB arbiter.

Parameters:
DEPTH, 4, number of reservation-station entries (power of 2, 2..16)
PREG_W, 6, physical register tag width
ROB_W, 5, ROB index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of all entries and the writeback slot
dispatch_valid  in  1  new op offered
dispatch_ready  out  1  entry available (= !full)
dispatch_op  in  4  ALU op encoding (add,sub,sll,slt,sltu,srl,sra,xor,or,and)
dispatch_bypass  in  1  result = operand b (lui-style)
dispatch_rob_id  in  ROB_W  ROB index
dispatch_pd  in  PREG_W  destination physical register
dispatch_src1_rdy / dispatch_src2_rdy  in  1 each  operand value already valid
dispatch_src1_tag / dispatch_src2_tag  in  PREG_W each  producer tag when not ready
dispatch_src1_val / dispatch_src2_val  in  32 each  operand value when ready
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  PREG_W  broadcast tag
cdb_data  in  32  broadcast value
alu_op  out  4  to ALU
alu_bypass  out  1  to ALU
alu_in_a / alu_in_b  out  32 each  to ALU
alu_out_f  in  32  ALU result (same cycle)
wb_valid  out  1  writeback slot holds result
wb_ready  in  1  CDB arbiter accepts
wb_rob_id  out  ROB_W  result ROB index
wb_pd  out  PREG_W  result tag
wb_data  out  32  result value

Behaviour:
- Reset (async): all entries invalid; wb_valid=0; wb_rob_id, wb_pd, wb_data=0; dispatch_ready=1; ALU outputs 0.
- Dispatch: on dispatch_valid && dispatch_ready, write any free entry (lowest index).
  - A source arriving not-ready whose tag equals cdb_tag while cdb_valid is captured as ready with cdb_data in the same edge.
- Wakeup: each cycle, every valid entry with an unready source matching cdb_tag (cdb_valid=1) stores cdb_data and marks it ready.
  - Woken entries become issue-eligible the following cycle; no same-cycle wake-and-issue.
- Select: eligible = valid && both sources ready. Choose the oldest in dispatch order; any age encoding is acceptable if strictly dispatch-ordered.
- Issue condition: an eligible entry exists && (!wb_valid || wb_ready).
  - On issue, alu_op/alu_bypass/alu_in_a/alu_in_b are driven combinationally from the selected entry.
  - On the same edge, alu_out_f, rob_id and pd latch into the writeback slot (wb_valid=1) and the entry frees.
  - When not issuing, ALU outputs are 0.
- Latency: dispatch with both sources ready at edge t → issue in cycle t+1 → wb_valid high after edge t+2 (2 cycles minimum).
- Writeback handshake:
  - The slot is held stable while wb_valid && !wb_ready.
  - On wb_ready with no issue, wb_valid clears next edge.
  - On wb_ready with issue, the slot reloads with no bubble. Throughput is 1 op/cycle.
- Full: dispatch_ready=0 when all DEPTH entries are valid, even if an entry issues that cycle (no same-cycle reuse). A freed entry is reusable next cycle.
- Flush: next edge invalidates all entries and clears wb_valid; dispatch and issue in the flush cycle are discarded. flush has priority over all other events.
- rst asserted mid-operation: immediate clear regardless of clk.
- A dispatched entry with both sources unready and no matching broadcast waits indefinitely. There is no timeout.

Test Plan:
1. Reset, then dispatch add with src1=5, src2=7 (both ready) and rob 3, pd 9 → alu_op=add, alu_in_a=5, alu_in_b=7 next cycle; wb_valid=1, wb_data=12, wb_rob_id=3, wb_pd=9 one cycle later.
2. Dispatch sub with src1 waiting on tag 12 and src2=1 ready. Broadcast cdb tag 12 / data 10 two cycles later → no issue before the wakeup; issue the cycle after wakeup; wb_data=9.
3. Fill DEPTH=4 entries with unready ops → dispatch_ready=0. Wake one → it issues, and dispatch_ready returns to 1 only on the following cycle.
4. Two entries become ready in the same cycle (dispatched in order A then B) → A issues first, B issues next cycle; results appear back-to-back with wb_ready=1.
5. Hold wb_ready=0 with a ready entry pending → wb outputs stable and no issue. Raise wb_ready → same-edge drain and reload, with no bubble.
6. Assert flush with 3 entries valid and wb_valid=1 → next cycle all entries are empty, wb_valid=0 and dispatch_ready=1. Async rst mid-cycle clears state immediately.
